hwpe_stream_sink_sequencer: RTL and testbench

Job sequencer in front of one hwpe_stream_sink. It queues address-generator job descriptors pushed by the HWPE controller and launches them back-to-back on the sink via the ctrl_sourcesink_t / flags_sourcesink_t control plane. It holds the active descriptor stable for the whole job, counts completions and flags hung jobs. It removes per-job start/done handshaking from the engine FSM.

---
 rtl/hwpe_stream_sink_sequencer_pkg.sv | 29 ++
 rtl/hwpe_stream_sink_sequencer_job_fifo.sv | 50 +++++
 rtl/hwpe_stream_sink_sequencer.sv | 113 +++++++++++
 tb/tb_hwpe_stream_sink_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_sink_sequencer_pkg.sv
// hwpe_stream_sink_sequencer_pkg: sink control-plane types and sequencer state encoding
package hwpe_stream_sink_sequencer_pkg;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] trans_size;
        logic [15:0] line_stride;
        logic [15:0] line_length;
        logic [15:0] feat_stride;
        logic [15:0] feat_length;
        logic [15:0] feat_roll;
        logic [15:0] loop_outer;
        logic        realign_type;
        logic [7:0]  step;
    } ctrl_addressgen_t;

    typedef struct packed {
        logic             req_start;
        ctrl_addressgen_t addressgen_ctrl;
    } ctrl_sourcesink_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } flags_sourcesink_t;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_START, SEQ_WAIT} state_sinkseq_t;

endpackage

// File: rtl/hwpe_stream_sink_sequencer_job_fifo.sv
// hwpe_stream_job_fifo: depth-N register FIFO with occupancy count and synchronous clear
module hwpe_stream_job_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       data_i,
    output T                       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign full_o  = count_o == (AW+1)'(DEPTH);
    assign empty_o = count_o == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (clear_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(do_push);
            rd_ptr  <= rd_ptr + AW'(do_pop);
            count_o <= count_o + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/hwpe_stream_sink_sequencer.sv
// hwpe_stream_sink_sequencer: queues address-generator jobs and launches them back-to-back on one sink
module hwpe_stream_sink_sequencer
    import hwpe_stream_sink_sequencer_pkg::*;
#(
    parameter int unsigned JOB_FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic                                  job_valid_i,
    output logic                                  job_ready_o,
    input  logic [$bits(ctrl_addressgen_t)-1:0]   job_i,
    output logic [$bits(ctrl_sourcesink_t)-1:0]   ctrl_o,
    input  logic [$bits(flags_sourcesink_t)-1:0]  flags_i,
    output logic                                  busy_o,
    output logic [$clog2(JOB_FIFO_DEPTH):0]       pending_o,
    output logic                                  done_evt_o,
    output logic [CNT_WIDTH-1:0]                  jobs_done_o,
    output logic                                  error_o
);
    localparam int unsigned WD_W    = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0;

    state_sinkseq_t    state_q, state_d;
    ctrl_addressgen_t  head, cur_job;
    flags_sourcesink_t flags;
    logic              full, empty, pop, launch, finish, timeout;
    logic [WD_W-1:0]   wdog_q;

    assign flags       = flags_i;
    assign job_ready_o = ~full;
    assign busy_o      = (state_q != SEQ_IDLE) | ~empty;
    assign ctrl_o      = ctrl_sourcesink_t'{req_start: state_q == SEQ_START, addressgen_ctrl: cur_job};

    hwpe_stream_job_fifo #(
        .T     (ctrl_addressgen_t),
        .DEPTH (JOB_FIFO_DEPTH)
    ) i_job_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (job_valid_i),
        .pop_i   (pop),
        .data_i  (job_i),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (pending_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      state_q <= SEQ_IDLE;
        else if (clear_i) state_q <= SEQ_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        launch  = 1'b0;
        finish  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                // empty jobs retire without ever touching the sink
                if (!empty && head.trans_size == '0) begin
                    pop    = 1'b1;
                    finish = 1'b1;
                end else if (!empty && flags.ready_start) begin
                    pop     = 1'b1;
                    launch  = 1'b1;
                    state_d = SEQ_START;
                end
            end
            SEQ_START: state_d = SEQ_WAIT;
            SEQ_WAIT: begin
                if (flags.done) begin
                    finish  = 1'b1;
                    state_d = SEQ_IDLE;
                end else if (TIMEOUT_CYCLES != 0 && wdog_q == WD_W'(TO_LAST)) begin
                    timeout = 1'b1;
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_job     <= '0;
            wdog_q      <= '0;
            done_evt_o  <= 1'b0;
            jobs_done_o <= '0;
            error_o     <= 1'b0;
        end else if (clear_i) begin
            cur_job     <= '0;
            wdog_q      <= '0;
            done_evt_o  <= 1'b0;
            jobs_done_o <= '0;
            error_o     <= 1'b0;
        end else begin
            if (launch) cur_job <= head;
            wdog_q      <= state_q == SEQ_WAIT ? wdog_q + 1'b1 : '0;
            done_evt_o  <= finish;
            jobs_done_o <= jobs_done_o + CNT_WIDTH'(finish);
            if (timeout) error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_sink_sequencer.sv
// tb_hwpe_stream_sink_sequencer: scoreboard bench with a behavioural sink model
module tb_hwpe_stream_sink_sequencer;
    import hwpe_stream_sink_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int TO    = 20;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic              clk_i = 1'b0, rst_ni = 1'b1, clear_i = 1'b0, job_valid_i = 1'b0;
    logic              job_ready_o, busy_o, done_evt_o, error_o;
    ctrl_addressgen_t  job_i;
    ctrl_sourcesink_t  ctrl_o;
    flags_sourcesink_t flags_i;
    logic [PW-1:0]     pending_o;
    logic [CW-1:0]     jobs_done_o;

    logic rs = 1'b0, mdone = 1'b0, fdone = 1'b0, hang = 1'b0, active = 1'b0, prev_req = 1'b0;
    int   beats, errors, checks, start_cnt, evt_cnt, exp_done;
    ctrl_addressgen_t exp_q[$];

    assign flags_i = '{ready_start: rs, done: mdone | fdone};
    always #5 clk_i = ~clk_i;

    hwpe_stream_sink_sequencer #(
        .JOB_FIFO_DEPTH (DEPTH),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .job_valid_i (job_valid_i),
        .job_ready_o (job_ready_o),
        .job_i       (job_i),
        .ctrl_o      (ctrl_o),
        .flags_i     (flags_i),
        .busy_o      (busy_o),
        .pending_o   (pending_o),
        .done_evt_o  (done_evt_o),
        .jobs_done_o (jobs_done_o),
        .error_o     (error_o)
    );

    // sink model: checks each launch against the scoreboard, raises done after trans_size beats
    initial begin
        ctrl_addressgen_t e;
        forever begin
            @(negedge clk_i);
            mdone = 1'b0;
            if (ctrl_o.req_start) begin
                start_cnt++;
                checks++;
                if (prev_req) begin
                    errors++;
                    $display("FAIL req_pulse: req_start high on consecutive cycles, expected single pulse");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL launch_order: req_start with no expected job, trans_size=%0d", ctrl_o.addressgen_ctrl.trans_size);
                end else begin
                    e = exp_q.pop_front();
                    if (ctrl_o.addressgen_ctrl !== e) begin
                        errors++;
                        $display("FAIL launch_desc: got %h expected %h", ctrl_o.addressgen_ctrl, e);
                    end
                end
                beats  = int'(ctrl_o.addressgen_ctrl.trans_size);
                active = 1'b1;
            end else if (active) begin
                beats--;
                if (beats == 0) begin
                    active = 1'b0;
                    mdone  = ~hang;
                end
            end
            prev_req = ctrl_o.req_start;
            if (done_evt_o) evt_cnt++;
        end
    end

    function automatic ctrl_addressgen_t mk(input int size);
        ctrl_addressgen_t j;
        j             = '0;
        j.base_addr   = $urandom;
        j.trans_size  = size;
        j.line_stride = 16'($urandom);
        j.line_length = 16'($urandom);
        j.step        = 8'($urandom);
        return j;
    endfunction

    task automatic clear_seq();
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i   = 1'b0;
        fdone     = 1'b0;
        active    = 1'b0;
        start_cnt = 0;
        evt_cnt   = 0;
        exp_done  = 0;
        exp_q.delete();
    endtask

    task automatic push(input ctrl_addressgen_t j);
        logic acc = 1'b0;
        job_i       = j;
        job_valid_i = 1'b1;
        for (int w = 0; w < 200; w++) begin
            acc = job_ready_o;
            @(negedge clk_i);
            if (acc) break;
        end
        job_valid_i = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL push_accept: job_ready_o stayed 0 for 200 cycles, expected acceptance");
        end else begin
            if (j.trans_size != 0) exp_q.push_back(j);
            exp_done++;
        end
    endtask

    task automatic drain(input string name);
        for (int w = 0; w < 600 && !(jobs_done_o == CW'(exp_done) && !busy_o); w++) @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (jobs_done_o !== CW'(exp_done)) begin
            errors++;
            $display("FAIL %s_jobs_done: got %0d expected %0d", name, jobs_done_o, exp_done);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got %b expected 0", name, busy_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_launches: %0d expected jobs never launched, expected 0", name, exp_q.size());
        end
        checks++;
        if (evt_cnt != exp_done) begin
            errors++;
            $display("FAIL %s_done_evt: got %0d pulses expected %0d", name, evt_cnt, exp_done);
        end
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        #2;
        checks++;
        if ({ctrl_o, done_evt_o, jobs_done_o, error_o, busy_o, pending_o} !== '0 || job_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_vals: ctrl=%h evt=%b cnt=%0d err=%b busy=%b pend=%0d ready=%b, expected zeros and ready=1",
                     ctrl_o, done_evt_o, jobs_done_o, error_o, busy_o, pending_o, job_ready_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single();
        ctrl_addressgen_t j = mk(8);
        rs = 1'b1;
        push(j);
        checks++;
        if (ctrl_o.req_start !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: req_start=%b one cycle after push, expected 0", ctrl_o.req_start);
        end
        @(negedge clk_i);
        checks++;
        if (ctrl_o.req_start !== 1'b1) begin
            errors++;
            $display("FAIL lat_start: req_start=%b two cycles after push, expected 1", ctrl_o.req_start);
        end
        @(negedge clk_i);
        checks++;
        if (ctrl_o.req_start !== 1'b0 || ctrl_o.addressgen_ctrl !== j) begin
            errors++;
            $display("FAIL desc_hold: req=%b desc=%h, expected req=0 desc=%h", ctrl_o.req_start, ctrl_o.addressgen_ctrl, j);
        end
        drain("single");
    endtask

    task automatic test_full();
        ctrl_addressgen_t j5 = mk(3);
        clear_seq();
        rs = 1'b0;
        for (int i = 0; i < 4; i++) push(mk(3));
        job_i       = j5;
        job_valid_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if (job_ready_o !== 1'b0 || pending_o !== PW'(4)) begin
            errors++;
            $display("FAIL full_stall: ready=%b pending=%0d, expected ready=0 pending=4", job_ready_o, pending_o);
        end
        rs = 1'b1;
        push(j5);
        drain("full");
    endtask

    task automatic test_zero_size();
        clear_seq();
        rs = 1'b1;
        push(mk(4));
        push(mk(0));
        push(mk(5));
        drain("zero");
        checks++;
        if (start_cnt != 2) begin
            errors++;
            $display("FAIL zero_no_start: got %0d req_start pulses expected 2", start_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_seq();
        hang = 1'b1;
        rs   = 1'b1;
        push(mk(6));
        push(mk(6));
        for (int w = 0; w < 20 && !ctrl_o.req_start; w++) @(negedge clk_i);
        checks++;
        if (ctrl_o.req_start !== 1'b1) begin
            errors++;
            $display("FAIL to_launch: req_start=%b, expected 1 within 20 cycles", ctrl_o.req_start);
        end
        repeat (20) @(negedge clk_i);
        checks++;
        if (error_o !== 1'b0) begin
            errors++;
            $display("FAIL to_early: error_o=%b after 19 wait cycles, expected 0", error_o);
        end
        @(negedge clk_i);
        checks++;
        if (error_o !== 1'b1 || done_evt_o !== 1'b0 || jobs_done_o !== '0) begin
            errors++;
            $display("FAIL to_fire: err=%b evt=%b cnt=%0d, expected err=1 evt=0 cnt=0", error_o, done_evt_o, jobs_done_o);
        end
        @(negedge clk_i);
        checks++;
        if (ctrl_o.req_start !== 1'b1) begin
            errors++;
            $display("FAIL to_next: req_start=%b after timeout, expected 1", ctrl_o.req_start);
        end
        clear_seq();
        push(mk(6));
        for (int w = 0; w < 20 && !ctrl_o.req_start; w++) @(negedge clk_i);
        repeat (20) @(negedge clk_i);
        fdone = 1'b1;
        @(negedge clk_i);
        fdone = 1'b0;
        checks++;
        if (error_o !== 1'b0 || done_evt_o !== 1'b1 || jobs_done_o !== CW'(1)) begin
            errors++;
            $display("FAIL to_done_wins: err=%b evt=%b cnt=%0d, expected err=0 evt=1 cnt=1", error_o, done_evt_o, jobs_done_o);
        end
        hang = 1'b0;
    endtask

    task automatic test_clear();
        clear_seq();
        hang = 1'b1;
        rs   = 1'b1;
        push(mk(0));
        for (int i = 0; i < 3; i++) push(mk(4));
        repeat (4) @(negedge clk_i);
        checks++;
        if (pending_o !== PW'(2) || jobs_done_o !== CW'(1) || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre: pending=%0d cnt=%0d busy=%b, expected 2 1 1", pending_o, jobs_done_o, busy_o);
        end
        clear_seq();
        checks++;
        if (pending_o !== '0 || ctrl_o !== '0 || busy_o !== 1'b0 || jobs_done_o !== '0) begin
            errors++;
            $display("FAIL clr_flush: pending=%0d ctrl=%h busy=%b cnt=%0d, expected all 0", pending_o, ctrl_o, busy_o, jobs_done_o);
        end
        fdone = 1'b1;
        @(negedge clk_i);
        fdone = 1'b0;
        checks++;
        if (done_evt_o !== 1'b0 || jobs_done_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_late_done: evt=%b cnt=%0d busy=%b, expected 0 0 0", done_evt_o, jobs_done_o, busy_o);
        end
        hang = 1'b0;
    endtask

    task automatic test_async_reset();
        clear_seq();
        hang = 1'b1;
        rs   = 1'b1;
        push(mk(0));
        push(mk(5));
        repeat (3) @(negedge clk_i);
        checks++;
        if (jobs_done_o !== CW'(1) || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: cnt=%0d busy=%b, expected 1 1", jobs_done_o, busy_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({ctrl_o, done_evt_o, jobs_done_o, error_o, busy_o, pending_o} !== '0 || job_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_vals: ctrl=%h evt=%b cnt=%0d err=%b busy=%b pend=%0d ready=%b, expected zeros and ready=1",
                     ctrl_o, done_evt_o, jobs_done_o, error_o, busy_o, pending_o, job_ready_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        hang   = 1'b0;
        active = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        job_i = '0;
        test_reset();
        test_single();
        test_full();
        test_zero_size();
        test_timeout();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
